// File: rtl/pipeline_controller.sv
// Control and hazard unit for the 5-stage pipelined ARM core: decodes InstrD, carries control
// through E/M/W, holds NZCV, evaluates condition codes and drives forwarding/stall/flush.
module pipeline_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        Match_1E_M,
    input  logic        Match_1E_W,
    input  logic        Match_2E_M,
    input  logic        Match_2E_W,
    input  logic        Match_12D_E,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        IgRnE,
    output logic        BranchTakenE,
    output logic        MemWriteM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE
);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       pcs;
        logic       flag_write;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       ig_rn;
        logic [3:0] cond;
    } de_t;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pcs;
    } em_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pcs;
    } mw_t;

    de_t        de_s;
    de_t        de_r;
    em_t        em_r;
    mw_t        mw_r;
    logic [3:0] flags_r;
    logic       cond_ex_s;
    logic       ldr_stall_s;
    logic       pc_wr_pending_s;
    logic       unused_s;

    // Fields that only the datapath consumes.
    assign unused_s = ^{InstrD[19:16], InstrD[11:0]};

    // Main decoder and ALU decoder for the fixed ISA subset.
    always_comb begin
        RegSrcD          = 2'b00;
        ImmSrcD          = 2'b00;
        de_s             = '0;
        de_s.cond        = InstrD[31:28];
        case (InstrD[27:26])
            2'b00: begin
                de_s.alu_src    = InstrD[25];
                de_s.reg_write  = 1'b1;
                de_s.flag_write = InstrD[20];
                case (InstrD[24:21])
                    4'b0100: de_s.alu_ctrl = 3'b000;
                    4'b0010: de_s.alu_ctrl = 3'b001;
                    4'b0000: de_s.alu_ctrl = 3'b010;
                    4'b1100: de_s.alu_ctrl = 3'b011;
                    4'b0001: de_s.alu_ctrl = 3'b100;
                    4'b1010: begin
                        de_s.alu_ctrl  = 3'b001;
                        de_s.reg_write = 1'b0;
                    end
                    4'b1101: begin
                        de_s.alu_ctrl = 3'b000;
                        de_s.ig_rn    = 1'b1;
                    end
                    default: begin
                        de_s.reg_write  = 1'b0;
                        de_s.flag_write = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                ImmSrcD      = 2'b01;
                de_s.alu_src = 1'b1;
                if (InstrD[20]) begin
                    de_s.reg_write  = 1'b1;
                    de_s.mem_to_reg = 1'b1;
                end else begin
                    RegSrcD        = 2'b10;
                    de_s.mem_write = 1'b1;
                end
            end
            2'b10: begin
                RegSrcD      = 2'b01;
                ImmSrcD      = 2'b10;
                de_s.alu_src = 1'b1;
                de_s.branch  = 1'b1;
            end
            default: begin
                de_s.cond = InstrD[31:28];
            end
        endcase
        de_s.pcs = (InstrD[15:12] == 4'd15) & de_s.reg_write & ~de_s.branch;
    end

    // Condition-code evaluation against the architectural flags {N,Z,C,V}.
    always_comb begin
        cond_ex_s = 1'b0;
        case (de_r.cond)
            4'b0000: cond_ex_s = flags_r[2];
            4'b0001: cond_ex_s = ~flags_r[2];
            4'b0010: cond_ex_s = flags_r[1];
            4'b0011: cond_ex_s = ~flags_r[1];
            4'b0100: cond_ex_s = flags_r[3];
            4'b0101: cond_ex_s = ~flags_r[3];
            4'b0110: cond_ex_s = flags_r[0];
            4'b0111: cond_ex_s = ~flags_r[0];
            4'b1000: cond_ex_s = flags_r[1] & ~flags_r[2];
            4'b1001: cond_ex_s = ~flags_r[1] | flags_r[2];
            4'b1010: cond_ex_s = (flags_r[3] == flags_r[0]);
            4'b1011: cond_ex_s = (flags_r[3] != flags_r[0]);
            4'b1100: cond_ex_s = ~flags_r[2] & (flags_r[3] == flags_r[0]);
            4'b1101: cond_ex_s = flags_r[2] | (flags_r[3] != flags_r[0]);
            4'b1110: cond_ex_s = 1'b1;
            default: cond_ex_s = 1'b0;
        endcase
    end

    // Pipeline registers and flags; E→M gates the side effects of a failed condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_r    <= '0;
            em_r    <= '0;
            mw_r    <= '0;
            flags_r <= 4'b0000;
        end else begin
            de_r           <= FlushE ? de_t'('0) : de_s;
            em_r.reg_write  <= de_r.reg_write & cond_ex_s;
            em_r.mem_write  <= de_r.mem_write & cond_ex_s;
            em_r.mem_to_reg <= de_r.mem_to_reg;
            em_r.pcs        <= de_r.pcs & cond_ex_s;
            mw_r.reg_write  <= em_r.reg_write;
            mw_r.mem_to_reg <= em_r.mem_to_reg;
            mw_r.pcs        <= em_r.pcs;
            if (de_r.flag_write & cond_ex_s) begin
                flags_r <= ALUFlags;
            end else begin
                flags_r <= flags_r;
            end
        end
    end

    assign ALUSrcE      = de_r.alu_src;
    assign ALUControlE  = de_r.alu_ctrl;
    assign IgRnE        = de_r.ig_rn;
    assign BranchTakenE = de_r.branch & cond_ex_s;
    assign MemWriteM    = em_r.mem_write;
    assign RegWriteW    = mw_r.reg_write;
    assign MemtoRegW    = mw_r.mem_to_reg;
    assign PCSrcW       = mw_r.pcs;

    // Forwarding selects; the younger Memory-stage result beats Writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (Match_1E_M & em_r.reg_write) begin
            ForwardAE = 2'b10;
        end else if (Match_1E_W & mw_r.reg_write) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end
        if (Match_2E_M & em_r.reg_write) begin
            ForwardBE = 2'b10;
        end else if (Match_2E_W & mw_r.reg_write) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

    // While reset is low the pipeline registers are clear, so only PCSrcD can reach FlushD.
    assign ldr_stall_s     = Match_12D_E & de_r.mem_to_reg & de_r.reg_write;
    assign pc_wr_pending_s = de_s.pcs | de_r.pcs | em_r.pcs;
    assign StallF          = reset & (ldr_stall_s | pc_wr_pending_s);
    assign StallD          = ldr_stall_s;
    assign FlushD          = pc_wr_pending_s | mw_r.pcs | BranchTakenE;
    assign FlushE          = ldr_stall_s | BranchTakenE;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: an instruction-level pipeline model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic [1:0]  RegSrcD, ImmSrcD, ForwardAE, ForwardBE;
    logic        ALUSrcE, IgRnE, BranchTakenE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW;
    logic [2:0]  ALUControlE;
    logic        StallF, StallD, FlushD, FlushE;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP    = 32'hEC00_0000;
    localparam logic [31:0] ADD123 = 32'hE082_1003;
    localparam logic [31:0] ADD211 = 32'hE081_2001;
    localparam logic [31:0] SUB415 = 32'hE041_4005;
    localparam logic [31:0] LDR10  = 32'hE590_1000;
    localparam logic [31:0] STR10  = 32'hE580_1000;
    localparam logic [31:0] SUBS0  = 32'hE050_0000;
    localparam logic [31:0] BEQ    = 32'h0A00_0000;
    localparam logic [31:0] BNE    = 32'h1A00_0000;
    localparam logic [31:0] MOVPC  = 32'hE1A0_F003;
    localparam logic [31:0] ADDNE  = 32'h1082_1003;
    localparam logic [31:0] ADDEQ  = 32'h0082_1003;

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlags(ALUFlags),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .IgRnE(IgRnE), .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
    );

    // Instruction-level semantics of the ISA subset.
    function automatic logic is_dp(input logic [31:0] i);  return i[27:26] == 2'b00; endfunction
    function automatic logic is_ldr(input logic [31:0] i); return i[27:26] == 2'b01 && i[20];  endfunction
    function automatic logic is_str(input logic [31:0] i); return i[27:26] == 2'b01 && !i[20]; endfunction
    function automatic logic is_b(input logic [31:0] i);   return i[27:26] == 2'b10; endfunction
    function automatic logic known_cmd(input logic [3:0] c);
        return c inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1101};
    endfunction
    function automatic logic writes_reg(input logic [31:0] i);
        return (is_dp(i) && known_cmd(i[24:21]) && i[24:21] != 4'b1010) || is_ldr(i);
    endfunction
    function automatic logic sets_flags(input logic [31:0] i);
        return is_dp(i) && known_cmd(i[24:21]) && i[20];
    endfunction
    function automatic logic writes_pc(input logic [31:0] i);
        return writes_reg(i) && i[15:12] == 4'hF;
    endfunction
    function automatic logic [2:0] alu_op(input logic [31:0] i);
        if (!is_dp(i)) return 3'b000;
        case (i[24:21])
            4'b0010, 4'b1010: return 3'b001;
            4'b0000:          return 3'b010;
            4'b1100:          return 3'b011;
            4'b0001:          return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction
    function automatic logic alu_src(input logic [31:0] i);
        return is_dp(i) ? i[25] : (i[27:26] == 2'b01 || i[27:26] == 2'b10);
    endfunction
    // Condition pairs share a base test; the low cond bit inverts it.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return base ^ c[0];
    endfunction

    // Model state: which instruction sits in each stage and whether it executed.
    logic        e_v, m_v, m_x, w_v, w_x;
    logic [31:0] e_i, m_i, w_i;
    logic [3:0]  nzcv;
    logic        x_cond, x_bt, x_rwm, x_rww, x_ldr, x_pend, x_pcsw;
    logic [1:0]  x_fa, x_fb, x_regsrc, x_immsrc;
    logic        x_stallf, x_flushd, x_flushe;

    always_comb begin
        x_cond   = e_v && cond_pass(e_i[31:28], nzcv);
        x_bt     = e_v && is_b(e_i) && x_cond;
        x_rwm    = m_v && m_x && writes_reg(m_i);
        x_rww    = w_v && w_x && writes_reg(w_i);
        x_ldr    = Match_12D_E && e_v && is_ldr(e_i);
        x_pend   = writes_pc(InstrD) || (e_v && writes_pc(e_i)) || (m_v && m_x && writes_pc(m_i));
        x_pcsw   = w_v && w_x && writes_pc(w_i);
        x_fa     = (Match_1E_M && x_rwm) ? 2'b10 : ((Match_1E_W && x_rww) ? 2'b01 : 2'b00);
        x_fb     = (Match_2E_M && x_rwm) ? 2'b10 : ((Match_2E_W && x_rww) ? 2'b01 : 2'b00);
        x_regsrc = is_str(InstrD) ? 2'b10 : (is_b(InstrD) ? 2'b01 : 2'b00);
        x_immsrc = (InstrD[27:26] == 2'b01) ? 2'b01 : ((InstrD[27:26] == 2'b10) ? 2'b10 : 2'b00);
        x_stallf = reset && (x_ldr || x_pend);
        x_flushd = x_pend || x_pcsw || x_bt;
        x_flushe = x_ldr || x_bt;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_v <= 1'b0; m_v <= 1'b0; w_v <= 1'b0; m_x <= 1'b0; w_x <= 1'b0;
            e_i <= 32'd0; m_i <= 32'd0; w_i <= 32'd0; nzcv <= 4'b0000;
        end else begin
            if (e_v && sets_flags(e_i) && x_cond) nzcv <= ALUFlags;
            w_v <= m_v; w_i <= m_i; w_x <= m_x;
            m_v <= e_v; m_i <= e_i; m_x <= x_cond;
            e_v <= !x_flushe; e_i <= InstrD;
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {3'b000, act}, {3'b000, exp});
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("RegSrcD",      {2'b00, RegSrcD},     {2'b00, x_regsrc});
        chk("ImmSrcD",      {2'b00, ImmSrcD},     {2'b00, x_immsrc});
        chk1("ALUSrcE",     ALUSrcE,              e_v && alu_src(e_i));
        chk("ALUControlE",  {1'b0, ALUControlE},  {1'b0, (e_v ? alu_op(e_i) : 3'b000)});
        chk1("IgRnE",       IgRnE,                e_v && is_dp(e_i) && e_i[24:21] == 4'b1101);
        chk1("BranchTakenE", BranchTakenE,        x_bt);
        chk1("MemWriteM",   MemWriteM,            m_v && m_x && is_str(m_i));
        chk1("RegWriteW",   RegWriteW,            x_rww);
        chk1("MemtoRegW",   MemtoRegW,            w_v && is_ldr(w_i));
        chk1("PCSrcW",      PCSrcW,               x_pcsw);
        chk("ForwardAE",    {2'b00, ForwardAE},   {2'b00, x_fa});
        chk("ForwardBE",    {2'b00, ForwardBE},   {2'b00, x_fb});
        chk1("StallF",      StallF,               x_stallf);
        chk1("StallD",      StallD,               x_ldr);
        chk1("FlushD",      FlushD,               x_flushd);
        chk1("FlushE",      FlushE,               x_flushe);
    end

    // mt = {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E}
    task automatic step(input logic [31:0] ins, input logic [3:0] fl, input logic [4:0] mt);
        @(posedge clk);
        #1;
        InstrD   = ins;
        ALUFlags = fl;
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = mt;
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) step(NOP, 4'b0000, 5'b00000);
    endtask

    initial begin
        reset = 1'b0;
        InstrD = NOP;
        ALUFlags = 4'b0000;
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = 5'b00000;
        step(NOP, 4'b0000, 5'b00000);
        step(ADD123, 4'b1111, 5'b11111);
        chk("rst ForwardAE", {2'b00, ForwardAE}, 4'h0);
        chk1("rst RegWriteW", RegWriteW, 1'b0);
        reset = 1'b1;

        // Back-to-back forwarding from Memory, then from Writeback, then M priority.
        step(ADD123, 4'b0000, 5'b00000);
        chk("add RegSrcD", {2'b00, RegSrcD}, 4'h0);
        step(SUB415, 4'b0000, 5'b00000);
        chk("add ALUControlE", {1'b0, ALUControlE}, 4'h0);
        step(NOP, 4'b0000, 5'b10000);
        chk("fwd M ForwardAE", {2'b00, ForwardAE}, 4'h2);
        chk("sub ALUControlE", {1'b0, ALUControlE}, 4'h1);
        drain();
        step(ADD123, 4'b0000, 5'b00000);
        step(NOP, 4'b0000, 5'b00000);
        step(SUB415, 4'b0000, 5'b00000);
        step(NOP, 4'b0000, 5'b01000);
        chk("fwd W ForwardAE", {2'b00, ForwardAE}, 4'h1);
        drain();
        step(ADD123, 4'b0000, 5'b00000);
        step(ADD211, 4'b0000, 5'b00000);
        step(SUB415, 4'b0000, 5'b00000);
        step(NOP, 4'b0000, 5'b11010);
        chk("prio ForwardAE", {2'b00, ForwardAE}, 4'h2);
        chk("prio ForwardBE", {2'b00, ForwardBE}, 4'h1);

        // Load-use stall for exactly one cycle, then forwarding from Writeback.
        drain();
        step(LDR10, 4'b0000, 5'b00000);
        step(ADD211, 4'b0000, 5'b00001);
        chk1("ldr StallF", StallF, 1'b1);
        chk1("ldr StallD", StallD, 1'b1);
        chk1("ldr FlushE", FlushE, 1'b1);
        step(ADD211, 4'b0000, 5'b00000);
        chk1("ldr StallF end", StallF, 1'b0);
        step(NOP, 4'b0000, 5'b01010);
        chk("ldr ForwardAE", {2'b00, ForwardAE}, 4'h1);
        chk("ldr ForwardBE", {2'b00, ForwardBE}, 4'h1);
        chk1("ldr RegWriteW", RegWriteW, 1'b1);
        chk1("ldr MemtoRegW", MemtoRegW, 1'b1);

        // Taken and not-taken conditional branch after SUBS sets Z.
        drain();
        step(SUBS0, 4'b0000, 5'b00000);
        step(BEQ, 4'b0100, 5'b00000);
        step(NOP, 4'b0000, 5'b00000);
        chk1("beq BranchTakenE", BranchTakenE, 1'b1);
        chk1("beq FlushD", FlushD, 1'b1);
        chk1("beq FlushE", FlushE, 1'b1);
        drain();
        step(SUBS0, 4'b0000, 5'b00000);
        step(BNE, 4'b0100, 5'b00000);
        step(NOP, 4'b0000, 5'b00000);
        chk1("bne BranchTakenE", BranchTakenE, 1'b0);
        chk1("bne FlushD", FlushD, 1'b0);

        // PC write: StallF three cycles, FlushD four, PCSrcW one.
        drain();
        step(MOVPC, 4'b0000, 5'b00000);
        chk1("pc StallF 1", StallF, 1'b1);
        step(NOP, 4'b0000, 5'b00000);
        chk1("pc IgRnE", IgRnE, 1'b1);
        step(NOP, 4'b0000, 5'b00000);
        chk1("pc StallF 3", StallF, 1'b1);
        step(NOP, 4'b0000, 5'b00000);
        chk1("pc StallF 4", StallF, 1'b0);
        chk1("pc FlushD 4", FlushD, 1'b1);
        chk1("pc PCSrcW", PCSrcW, 1'b1);
        step(NOP, 4'b0000, 5'b00000);
        chk1("pc FlushD 5", FlushD, 1'b0);

        // Conditional execution with Z set.
        drain();
        step(SUBS0, 4'b0000, 5'b00000);
        step(ADDNE, 4'b0100, 5'b00000);
        step(NOP, 4'b0000, 5'b00000);
        step(NOP, 4'b0000, 5'b10000);
        chk("ne ForwardAE", {2'b00, ForwardAE}, 4'h0);
        step(NOP, 4'b0000, 5'b00000);
        chk1("ne RegWriteW", RegWriteW, 1'b0);
        step(ADDEQ, 4'b0000, 5'b00000);
        step(NOP, 4'b0000, 5'b00000);
        step(NOP, 4'b0000, 5'b10000);
        chk("eq ForwardAE", {2'b00, ForwardAE}, 4'h2);
        step(NOP, 4'b0000, 5'b00000);
        chk1("eq RegWriteW", RegWriteW, 1'b1);

        // Store path.
        step(STR10, 4'b0000, 5'b00000);
        chk("str RegSrcD", {2'b00, RegSrcD}, 4'h2);
        chk("str ImmSrcD", {2'b00, ImmSrcD}, 4'h1);
        step(NOP, 4'b0000, 5'b00000);
        step(NOP, 4'b0000, 5'b00000);
        chk1("str MemWriteM", MemWriteM, 1'b1);

        // Reset asserted in the middle of a load-use stall.
        drain();
        step(LDR10, 4'b0000, 5'b00000);
        step(ADD211, 4'b0000, 5'b00001);
        chk1("pre-rst StallF", StallF, 1'b1);
        reset = 1'b0;
        #1;
        chk1("mid-rst StallF", StallF, 1'b0);
        chk1("mid-rst StallD", StallD, 1'b0);
        chk1("mid-rst FlushE", FlushE, 1'b0);
        chk1("mid-rst ALUSrcE", ALUSrcE, 1'b0);
        InstrD = MOVPC;
        #1;
        chk1("mid-rst FlushD", FlushD, 1'b1);
        chk1("mid-rst StallF pc", StallF, 1'b0);
        step(NOP, 4'b0000, 5'b00000);
        reset = 1'b1;
        step(BEQ, 4'b0000, 5'b00000);
        chk("post-rst RegSrcD", {2'b00, RegSrcD}, 4'h1);
        chk("post-rst ImmSrcD", {2'b00, ImmSrcD}, 4'h2);
        step(NOP, 4'b0000, 5'b00000);
        chk1("post-rst BranchTakenE", BranchTakenE, 1'b0);
        chk1("post-rst ALUSrcE", ALUSrcE, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Control and hazard unit for the 5-stage pipelined ARM core (Fetch, Decode, Execute, Memory, Writeback).
- Decodes InstrD and pipelines the control bits through the E, M and W stages.
- Holds the NZCV flags and evaluates condition codes in the Execute stage.
- Generates the forwarding, stall and flush controls for the datapath from the datapath's register-match signals.

Parameters:
- none (the ISA subset is fixed)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- InstrD  in  32  Decode-stage instruction
- ALUFlags  in  4  Execute-stage ALU flags {N,Z,C,V}
- Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  in  1 each  Execute-stage source register equals WA3M / WA3W
- Match_12D_E  in  1  a Decode-stage source register equals WA3E
- RegSrcD  out  2  register-address source select
- ImmSrcD  out  2  immediate-extend select
- ALUSrcE  out  1  Execute-stage ALU source-B select
- ALUControlE  out  3  Execute-stage ALU operation
- IgRnE  out  1  force ALU source A to zero (MOV)
- BranchTakenE  out  1  branch taken in Execute
- MemWriteM  out  1  data-memory write enable
- RegWriteW  out  1  register-file write enable
- MemtoRegW  out  1  writeback selects memory read data
- PCSrcW  out  1  writeback targets PC
- ForwardAE, ForwardBE  out  2 each  forwarding selects (00 register file, 01 ResultW, 10 ALUOutM)
- StallF, StallD, FlushD, FlushE  out  1 each  hazard controls

Behaviour:
- Instruction fields: Cond=[31:28], Op=[27:26], Funct=[25:20] (I=25, cmd=24:21, S=20, L=20), Rd=[15:12].
- Decode, combinational from InstrD:
  - Op=00 (data processing): RegSrcD=00; ImmSrcD=00; ALUSrc=I.
  - Op=01 (LDR/STR):
    - Both: ImmSrcD=01, ALUSrc=1, ALU ADD.
    - STR: RegSrcD=10, MemWrite=1.
    - LDR: RegSrcD=00, RegWrite=1, MemtoReg=1.
  - Op=10 (B): RegSrcD=01; ImmSrcD=10; ALUSrc=1; ALU ADD; Branch=1.
  - Op=11: no-op, all enables 0.
- ALU mapping by cmd:
  - ADD 0100→000; SUB 0010→001; AND 0000→010; ORR 1100→011; EOR 0001→100.
  - CMP 1010→001 with RegWrite=0.
  - MOV 1101→000 with IgRn=1.
  - Any other cmd: RegWrite=0 and FlagWrite=0.
- FlagWrite = S bit, data-processing only.
- PCS = (Rd==15 & RegWrite) for non-branches only.
- D→E register: {RegWrite, MemWrite, MemtoReg, Branch, PCS, FlagWrite, ALUSrc, ALUControl, IgRn, Cond}.
  - Cleared by FlushE; otherwise loads every cycle.
- Flags register (4 bits):
  - Loads ALUFlags on the clock edge when FlagWriteE & CondExE.
  - Resets to 0000.
- CondExE is combinational from CondE and the flags register:
  - EQ..LE per the ARM definitions.
  - AL=1; 1111=0.
- E→M register: {RegWriteE&CondExE, MemWriteE&CondExE, MemtoRegE, PCSE&CondExE}.
- M→W register: {RegWrite, MemtoReg, PCSrc}.
- BranchTakenE = BranchE & CondExE.
- PCSrcD = PCS decoded from InstrD; PCSrcE is the D→E register copy (ungated).
- ForwardAE:
  - 10 if Match_1E_M & RegWriteM.
  - else 01 if Match_1E_W & RegWriteW.
  - else 00.
  - M has priority when both match.
- ForwardBE: same rule using Match_2E_*.
- LDRstall = Match_12D_E & MemtoRegE & RegWriteE.
- PCWrPending = PCSrcD | PCSrcE | PCSrcM.
- StallF = LDRstall | PCWrPending.
- StallD = LDRstall.
- FlushD = PCWrPending | PCSrcW | BranchTakenE.
- FlushE = LDRstall | BranchTakenE.
- Simultaneous LDRstall and BranchTakenE: the flush wins, Decode is flushed.
- Reset, at any time including mid-stall:
  - All pipeline registers and flags clear immediately.
  - RegWriteW, MemWriteM, MemtoRegW, PCSrcW, BranchTakenE, ALUSrcE, IgRnE = 0; ALUControlE=000.
  - ForwardAE = ForwardBE = 00.
  - StallF/StallD/FlushE = 0. FlushD = PCSrcD, the only term still live while reset is asserted.
  - Decode outputs follow InstrD.
- Latency: control reaches E/M/W exactly 1/2/3 cycles after Decode, unless flushed.

Test Plan:
- Reset: assert reset=0 mid-LDR-stall → all registered outputs 0, ForwardAE=ForwardBE=00, flags=0000; release reset → first instruction decodes normally.
- ADD R1,R2,R3 then SUB R4,R1,R5 back-to-back → with SUB in Execute (Match_1E_M=1), ForwardAE=10. One NOP between them → ForwardAE=01.
- LDR R1,[R0] then ADD R2,R1,R1 (Match_12D_E=1 with LDR in Execute) → StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle ForwardAE=ForwardBE=01, RegWriteW=1, MemtoRegW=1 for the LDR.
- SUBS R0,R0,R0 (ALUFlags=0100) then BEQ → BranchTakenE=1, FlushD=FlushE=1 in BEQ's Execute cycle. BNE in its place → BranchTakenE=0, no flush.
- MOV PC,R3 → StallF=1 for 3 cycles; FlushD=1 for 4 cycles; PCSrcW pulses 1 cycle.
- Z flag=1 then ADDNE R1,R2,R3 → RegWriteM=0, RegWriteW=0. ADDEQ instead → RegWriteW=1.
